// File: rtl/fn_des_izq.sv
// Registered 32-bit logical left shifter (SLL/SLLI path).
// Five-stage logarithmic mux network feeding a single output register.
module fn_des_izq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [4:0]  b,
    output logic [31:0] Y
);

    logic [31:0] stg0, stg1, stg2, stg3, stg4;
    logic [31:0] y_d, y_q;

    // Stage k shifts by 2^k when b[k] is set; vacated bits fill with zero.
    always_comb begin
        stg0 = b[0] ? {a[30:0],    1'b0}  : a;
        stg1 = b[1] ? {stg0[29:0], 2'b0}  : stg0;
        stg2 = b[2] ? {stg1[27:0], 4'b0}  : stg1;
        stg3 = b[3] ? {stg2[23:0], 8'b0}  : stg2;
        stg4 = b[4] ? {stg3[15:0], 16'b0} : stg3;
        y_d  = stg4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign Y = y_q;

endmodule

// File: tb/tb_fn_des_izq.sv
// Directed and sweep checks for the registered left shifter.
module tb_fn_des_izq;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [4:0]  b;
    logic [31:0] Y;

    int unsigned n_cmp;
    int unsigned n_err;

    fn_des_izq dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .Y   (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, then step past the next rising edge.
    task automatic drive(input logic [31:0] av, input logic [4:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a   = 32'hFFFF_FFFF;
        b   = 5'd3;
        #1;
        n_cmp++;
        if (Y !== 32'h0) begin
            n_err++;
            $display("FAIL reset_initial: Y=%h expected %h", Y, 32'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (Y !== 32'h0) begin
            n_err++;
            $display("FAIL reset_held: Y=%h expected %h", Y, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_walk;
        logic [4:0]  bs [4];
        logic [31:0] ex [4];
        bs = '{5'd0, 5'd5, 5'd10, 5'd15};
        ex = '{32'h0000_0001, 32'h0000_0020, 32'h0000_0400, 32'h0000_8000};
        for (int i = 0; i < 4; i++) begin
            drive(32'h1, bs[i]);
            n_cmp++;
            if (Y !== ex[i]) begin
                n_err++;
                $display("FAIL walk_b%0d: Y=%h expected %h", bs[i], Y, ex[i]);
            end
        end
    endtask

    task automatic test_patterns;
        logic [31:0] av [6];
        logic [4:0]  bv [6];
        logic [31:0] ex [6];
        av = '{32'h0000_0001, 32'h8000_0001, 32'hFFFF_FFFF,
               32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_A5A5};
        bv = '{5'd31, 5'd1, 5'd4, 5'd0, 5'd16, 5'd1};
        ex = '{32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFF0,
               32'hDEAD_BEEF, 32'h5678_0000, 32'h4B4B_4B4A};
        for (int i = 0; i < 6; i++) begin
            drive(av[i], bv[i]);
            n_cmp++;
            if (Y !== ex[i]) begin
                n_err++;
                $display("FAIL pattern_%0d: a=%h b=%0d Y=%h expected %h",
                         i, av[i], bv[i], Y, ex[i]);
            end
        end
        drive(32'h0, 5'd13);
        n_cmp++;
        if (Y !== 32'h0) begin
            n_err++;
            $display("FAIL zero_operand: Y=%h expected %h", Y, 32'h0);
        end
        drive(32'hC000_0003, 5'd31);
        n_cmp++;
        if (Y !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL b31_lsb: Y=%h expected %h", Y, 32'h8000_0000);
        end
    endtask

    task automatic test_hold_between_edges;
        drive(32'h0000_00F0, 5'd4);
        @(negedge clk);
        a = 32'h1111_1111;
        b = 5'd7;
        #2;
        n_cmp++;
        if (Y !== 32'h0000_0F00) begin
            n_err++;
            $display("FAIL hold_between_edges: Y=%h expected %h", Y, 32'h0000_0F00);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (Y !== 32'h8888_8880) begin
            n_err++;
            $display("FAIL load_after_hold: Y=%h expected %h", Y, 32'h8888_8880);
        end
    endtask

    task automatic test_async_reset;
        drive(32'h1, 5'd15);
        n_cmp++;
        if (Y !== 32'h0000_8000) begin
            n_err++;
            $display("FAIL pre_async: Y=%h expected %h", Y, 32'h0000_8000);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (Y !== 32'h0) begin
            n_err++;
            $display("FAIL async_clear: Y=%h expected %h", Y, 32'h0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (Y !== 32'h0) begin
            n_err++;
            $display("FAIL reset_across_edge: Y=%h expected %h", Y, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        a   = 32'h3;
        b   = 5'd2;
        @(posedge clk);
        #1;
        n_cmp++;
        if (Y !== 32'h0000_000C) begin
            n_err++;
            $display("FAIL post_reset_load: Y=%h expected %h", Y, 32'h0000_000C);
        end
    endtask

    task automatic test_sweep;
        logic [31:0] av;
        logic [31:0] ex;
        for (int i = 0; i < 32; i++) begin
            av = $urandom;
            ex = av << i;
            drive(av, 5'(i));
            n_cmp++;
            if (Y !== ex) begin
                n_err++;
                $display("FAIL sweep_b%0d: a=%h Y=%h expected %h", i, av, Y, ex);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_walk();
        test_patterns();
        test_hold_between_edges();
        test_async_reset();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
